// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multicycle load/store sequencer placed ahead of the
// size-handler mux. It latches one request at a time and drives the
// word-aligned address. For sb/sh it reads the word first so the size
// handler can merge the new bytes (read-modify-write). Illegal ops and
// misaligned addresses are answered with a one-cycle done+err pulse.
module mem_access_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [2:0]  sh_sel,
  output logic        mdr_load
);

  // Size-handler op encodings
  localparam logic [2:0] OP_SB = 3'b000;
  localparam logic [2:0] OP_SW = 3'b001;
  localparam logic [2:0] OP_SH = 3'b010;
  localparam logic [2:0] OP_LW = 3'b100;
  localparam logic [2:0] OP_LH = 3'b101;
  localparam logic [2:0] SEL_PASS = 3'b111;

  // READ counts down from the latency, so it lasts exactly MEM_LATENCY cycles
  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [2:0]  op_reg;
  logic [29:0] word_addr_reg;   // only the word part of the address is ever used
  logic        req_ok;
  logic        op_is_rmw;       // sb/sh need a read before the write

  // The memory always sees the word-aligned version of the latched address
  assign mem_addr = {word_addr_reg, 2'b00};

  // Stores of less than a word go through the read-modify-write path
  assign op_is_rmw = (op_reg == OP_SB) || (op_reg == OP_SH);

  // Legality of the request presented on the inputs while in IDLE
  always_comb begin
    req_ok = 1'b1;
    if (op[2:1] == 2'b11)
      req_ok = 1'b0;
    else if (((op == OP_SW) || (op == OP_LW)) && (addr[1:0] != 2'b00))
      req_ok = 1'b0;
    else if (((op == OP_SH) || (op == OP_LH)) && addr[0])
      req_ok = 1'b0;
  end

  // State, latency counter and request latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 3'd0;
      op_reg        <= 3'd0;
      word_addr_reg <= 30'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if ((state_reg == S_IDLE) && start) begin
        op_reg        <= op;
        word_addr_reg <= addr[31:2];
      end
    end
  end

  // Next-state logic and state-decoded strobes
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    mem_wr     = 1'b0;
    mdr_load   = 1'b0;
    sh_sel     = SEL_PASS;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (!req_ok) begin
            state_next = S_FAULT;
          end else if (op == OP_SW) begin
            state_next = S_WRITE;
          end else begin
            state_next = S_READ;
            cnt_next   = LAT;
          end
        end
      end
      S_READ: begin
        cnt_next = cnt_reg - 3'd1;
        // <= 1 rather than == 1 so a stray zero count cannot wrap around
        if (cnt_reg <= 3'd1)
          state_next = op_is_rmw ? S_WRITE : S_LOAD;
      end
      S_LOAD: begin
        sh_sel     = op_reg;
        mdr_load   = 1'b1;
        state_next = S_DONE;
      end
      S_WRITE: begin
        sh_sel     = op_reg;
        mem_wr     = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_FAULT: begin
        busy       = 1'b0;
        done       = 1'b1;
        err        = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of the load/store sequencer with
// MEM_LATENCY=1 (dut1) and MEM_LATENCY=3 (dut3); one line per transaction.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        use3;
  logic [2:0]  op;
  logic [31:0] addr;

  logic        start1, start3;
  logic        busy1, done1, err1, mem_wr1, mdr_load1;
  logic        busy3, done3, err3, mem_wr3, mdr_load3;
  logic [31:0] mem_addr1, mem_addr3;
  logic [2:0]  sh_sel1, sh_sel3;

  logic        o_busy, o_done, o_err, o_mem_wr, o_mdr_load;
  logic [31:0] o_mem_addr;
  logic [2:0]  o_sh_sel;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign start1 = start & ~use3;
  assign start3 = start & use3;

  mem_access_ctrl #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op), .addr(addr),
    .busy(busy1), .done(done1), .err(err1), .mem_addr(mem_addr1),
    .mem_wr(mem_wr1), .sh_sel(sh_sel1), .mdr_load(mdr_load1)
  );

  mem_access_ctrl #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .op(op), .addr(addr),
    .busy(busy3), .done(done3), .err(err3), .mem_addr(mem_addr3),
    .mem_wr(mem_wr3), .sh_sel(sh_sel3), .mdr_load(mdr_load3)
  );

  assign o_busy     = use3 ? busy3     : busy1;
  assign o_done     = use3 ? done3     : done1;
  assign o_err      = use3 ? err3      : err1;
  assign o_mem_wr   = use3 ? mem_wr3   : mem_wr1;
  assign o_mdr_load = use3 ? mdr_load3 : mdr_load1;
  assign o_mem_addr = use3 ? mem_addr3 : mem_addr1;
  assign o_sh_sel   = use3 ? sh_sel3   : sh_sel1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch it to completion. Cycle numbers count edges
  // after the accepting edge; -1 means "never".
  task automatic do_req(input bit s, input logic [2:0] o, input logic [31:0] a,
                        input bit hold, input int exp_done, input int exp_wr,
                        input int exp_ld, input logic [2:0] exp_sel,
                        input logic [31:0] exp_maddr, input bit exp_err,
                        input string tag);
    int done_cyc = -1;
    int wr_cyc = -1;
    int ld_cyc = -1;
    int wr_n = 0;
    int ld_n = 0;
    int sel_bad = 0;
    logic [2:0]  sel_at = 3'bxxx;
    logic [31:0] maddr_c1 = 32'hx;
    logic        busy_c1 = 1'bx;
    logic        err_at = 1'bx;
    @(negedge clk);
    use3  = s;
    start = 1'b1;
    op    = o;
    addr  = a;
    @(posedge clk);
    #1;
    if (!hold) begin
      // Post-acceptance input changes must not affect the request
      start = 1'b0;
      op    = 3'b110;
      addr  = 32'hffff_fffd;
    end
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        busy_c1  = o_busy;
        maddr_c1 = o_mem_addr;
      end
      if (o_mem_wr) begin
        wr_n++;
        wr_cyc = c;
        sel_at = o_sh_sel;
      end
      if (o_mdr_load) begin
        ld_n++;
        ld_cyc = c;
        sel_at = o_sh_sel;
      end
      if (!o_mem_wr && !o_mdr_load && o_sh_sel != 3'b111) sel_bad++;
      if (o_done) begin
        done_cyc = c;
        err_at   = o_err;
      end
    end
    check({tag, " done_cycle"}, done_cyc, exp_done);
    check({tag, " err"}, {31'd0, err_at}, {31'd0, exp_err});
    check({tag, " mem_wr_count"}, wr_n, (exp_wr >= 0) ? 1 : 0);
    check({tag, " mem_wr_cycle"}, wr_cyc, exp_wr);
    check({tag, " mdr_load_count"}, ld_n, (exp_ld >= 0) ? 1 : 0);
    check({tag, " mdr_load_cycle"}, ld_cyc, exp_ld);
    if (exp_wr >= 0 || exp_ld >= 0)
      check({tag, " sh_sel"}, {29'd0, sel_at}, {29'd0, exp_sel});
    check({tag, " mem_addr"}, maddr_c1, exp_maddr);
    check({tag, " busy_c1"}, {31'd0, busy_c1}, {31'd0, ~exp_err});
    check({tag, " idle_sel"}, sel_bad, 0);
    $display("txn %-10s op=%b addr=%h done@%0d wr@%0d ld@%0d err=%b maddr=%h",
             tag, o, a, done_cyc, wr_cyc, ld_cyc, err_at, maddr_c1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0;
    use3  = 1'b0;
    op    = 3'b000;
    addr  = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst busy", {31'd0, busy1}, 32'd0);
    check("rst done", {31'd0, done1}, 32'd0);
    check("rst err", {31'd0, err1}, 32'd0);
    check("rst mem_wr", {31'd0, mem_wr1}, 32'd0);
    check("rst mdr_load", {31'd0, mdr_load1}, 32'd0);
    check("rst sh_sel", {29'd0, sh_sel1}, 32'd7);
    check("rst mem_addr", mem_addr1, 32'd0);
    check("rst mem_addr3", mem_addr3, 32'd0);
    $display("txn reset      busy=%b done=%b sh_sel=%b mem_addr=%h", busy1, done1, sh_sel1, mem_addr1);

    //     dut op      addr          hold done wr  ld  sel     maddr         err tag
    do_req(0, 3'b100, 32'h0000_0010, 0,   3, -1,  2, 3'b100, 32'h0000_0010, 0, "lw_l1");
    do_req(1, 3'b000, 32'h0000_0007, 0,   5,  4, -1, 3'b000, 32'h0000_0004, 0, "sb_l3");
    do_req(0, 3'b001, 32'h0000_0020, 0,   2,  1, -1, 3'b001, 32'h0000_0020, 0, "sw_l1");
    do_req(0, 3'b101, 32'h0000_0003, 0,   1, -1, -1, 3'b000, 32'h0000_0000, 1, "lh_mis");
    do_req(0, 3'b110, 32'h0000_0000, 0,   1, -1, -1, 3'b000, 32'h0000_0000, 1, "op110");
    do_req(0, 3'b001, 32'h0000_0022, 0,   1, -1, -1, 3'b000, 32'h0000_0020, 1, "sw_mis");
    do_req(1, 3'b111, 32'h0000_0008, 0,   1, -1, -1, 3'b000, 32'h0000_0008, 1, "op111");
    do_req(1, 3'b010, 32'h0000_0006, 0,   5,  4, -1, 3'b010, 32'h0000_0004, 0, "sh_l3");
    do_req(0, 3'b011, 32'h0000_0013, 0,   3, -1,  2, 3'b011, 32'h0000_0010, 0, "lb_l1");
    do_req(1, 3'b101, 32'h0000_001a, 0,   5, -1,  4, 3'b101, 32'h0000_0018, 0, "lh_l3");
    do_req(1, 3'b100, 32'h8000_0104, 0,   5, -1,  4, 3'b100, 32'h8000_0104, 0, "lw_l3");
    do_req(0, 3'b010, 32'h0000_0011, 0,   1, -1, -1, 3'b000, 32'h0000_0010, 1, "sh_mis");

    // start held high throughout an lh: one service, re-accept on first IDLE cycle
    do_req(0, 3'b101, 32'h0000_0002, 1,   3, -1,  2, 3'b101, 32'h0000_0000, 0, "lh_hold");
    @(negedge clk);
    check("hold idle_after_done", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    check("hold reaccept", {31'd0, o_busy}, 32'd1);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_done) seen++;
    end
    check("hold second_done", seen, 1);
    $display("txn hold_next  second request done pulses=%0d", seen);

    // Reset during READ of an sh on dut3
    @(negedge clk);
    use3  = 1'b1;
    start = 1'b1;
    op    = 3'b010;
    addr  = 32'h0000_0002;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid busy_before", {31'd0, o_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid busy", {31'd0, o_busy}, 32'd0);
    check("rstmid sh_sel", {29'd0, o_sh_sel}, 32'd7);
    check("rstmid mem_addr", o_mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_mem_wr || o_done) seen++;
    end
    check("rstmid no_activity", seen, 0);
    $display("txn rst_read   aborted sh, later activity=%0d", seen);
    do_req(1, 3'b011, 32'h0000_0005, 0,   5, -1,  4, 3'b011, 32'h0000_0004, 0, "lb_after");

    // Reset during WRITE of an sw on dut1: mem_wr drops asynchronously
    @(negedge clk);
    use3  = 1'b0;
    start = 1'b1;
    op    = 3'b001;
    addr  = 32'h0000_0040;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("rstwr mem_wr_before", {31'd0, o_mem_wr}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstwr mem_wr", {31'd0, o_mem_wr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (o_done || o_mem_wr) seen++;
    end
    check("rstwr no_done", seen, 0);
    $display("txn rst_write  aborted sw, later activity=%0d", seen);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
